mo_wr_arbiter: RTL

- Shares the single write-splitter start port (`start_valid/start_ready/start_addr/len`) among `NUM_CH` DMA write channels, using round-robin arbitration.
- Keeps an in-order completion queue of granted requests. It drains that queue by counting the bytes reported by the splitter's B-channel retirements, and pulses a per-channel done when a request's last burst completes.
- Sits between the DMA channel front-ends and the MO write FIFO/splitter.

---
 rtl/axi_pkg.sv | 17 +
 rtl/mo_ord_fifo.sv | 96 +++++++++
 rtl/mo_wr_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI/DMA type definitions.
//   addr_64_t    : 64-bit byte address.
//   MO_WR_MAX_CH : upper bound on MO write arbiter channel count.
//   mo_ord_t     : completion-queue entry {ch_id, rem_bytes}.
package axi_pkg;

    typedef logic [63:0] addr_64_t;

    localparam int unsigned MO_WR_MAX_CH = 8;
    localparam int unsigned MO_CH_ID_W   = $clog2(MO_WR_MAX_CH);

    typedef struct packed {
        logic [MO_CH_ID_W-1:0] ch_id;
        logic [31:0]           rem_bytes;
    } mo_ord_t;

endpackage

// File: rtl/mo_ord_fifo.sv
// In-order completion queue for the MO write arbiter.
// Ports:
//   clk, rstn      : clock, async active-low reset
//   push_i         : enqueue push_data_i at the tail
//   push_data_i    : {ch_id, rem_bytes} of a granted request
//   b_done_i       : a burst retired; subtract b_len_i beats from the head
//   b_len_i        : beat count of the retired burst
//   pop_o          : head entry drained this cycle (combinational)
//   pop_id_o       : channel id of the head entry
//   full_o/empty_o : registered-count decodes
module mo_ord_fifo
    import axi_pkg::*;
#(
    parameter int unsigned Depth     = 4,
    parameter int unsigned DataShift = 5
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push_i,
    input  mo_ord_t               push_data_i,
    input  logic                  b_done_i,
    input  logic [8:0]            b_len_i,
    output logic                  pop_o,
    output logic [MO_CH_ID_W-1:0] pop_id_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    mo_ord_t             mem_q [Depth];
    mo_ord_t             mem_d [Depth];
    logic [PtrW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [31:0]         dec_bytes;
    mo_ord_t             head;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        mem_d     = mem_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        cnt_d     = cnt_q;
        pop_o     = 1'b0;
        head      = mem_q[rptr_q];
        dec_bytes = {23'd0, b_len_i} << DataShift;

        // Compare before subtracting so an overshooting last burst cannot wrap.
        if (b_done_i && (cnt_q != '0)) begin
            if (head.rem_bytes <= dec_bytes) begin
                pop_o  = 1'b1;
                rptr_d = ptr_inc(rptr_q);
            end else begin
                mem_d[rptr_q].rem_bytes = head.rem_bytes - dec_bytes;
            end
        end

        if (push_i) begin
            mem_d[wptr_q] = push_data_i;
            wptr_d        = ptr_inc(wptr_q);
        end

        unique case ({push_i, pop_o})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    assign pop_id_o = head.ch_id;
    assign full_o   = (cnt_q == CntW'(Depth));
    assign empty_o  = (cnt_q == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // A retirement with nothing outstanding indicates a splitter/arbiter desync.
    a_no_bdone_when_empty: assert property (@(posedge clk) disable iff (!rstn)
        b_done_i |-> (cnt_q != '0));

endmodule

// File: rtl/mo_wr_arbiter.sv
// Round-robin arbiter sharing the write-splitter start port among NUM_CH DMA
// write channels, with an in-order completion queue that turns B-channel burst
// retirements into per-channel done pulses.
// Ports:
//   clk, rstn                 : clock, async active-low reset
//   ch_req_valid/ready        : per-channel request handshake
//   ch_req_addr/len           : per-channel start address / byte length
//   ch_done                   : one-cycle completion pulse per channel
//   ch_err                    : one-cycle reject pulse (length check build only)
//   start_valid/ready/addr/len: splitter start port
//   b_done, b_len             : burst retirement from the splitter B channel
//   ord_full, ord_empty       : completion-queue status
// Build option: MO_WR_ARB_LEN_CHECK_EN rejects zero-length or non-beat-multiple
// requests instead of forwarding them.
module mo_wr_arbiter
    import axi_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned ORD_DEPTH  = 4,
    parameter type         addr_t     = addr_64_t
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NUM_CH-1:0]        ch_req_valid,
    output logic [NUM_CH-1:0]        ch_req_ready,
    input  addr_t [NUM_CH-1:0]       ch_req_addr,
    input  logic [NUM_CH-1:0][31:0]  ch_req_len,
    output logic [NUM_CH-1:0]        ch_done,
    output logic [NUM_CH-1:0]        ch_err,
    output logic                     start_valid,
    input  logic                     start_ready,
    output addr_t                    start_addr,
    output logic [31:0]              start_len,
    input  logic                     b_done,
    input  logic [8:0]               b_len,
    output logic                     ord_full,
    output logic                     ord_empty
);

    localparam int unsigned BPB        = DATA_WIDTH / 8;
    localparam int unsigned DATA_SHIFT = $clog2(BPB);
    localparam int unsigned IdW        = $clog2(NUM_CH);
    localparam int unsigned SumW       = IdW + 1;

    typedef enum logic [0:0] {StArb, StIssue} state_e;

    state_e              state_q, state_d;
    logic [IdW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]      grant_id_q, grant_id_d;
    addr_t               grant_addr_q, grant_addr_d;
    logic [31:0]         grant_len_q, grant_len_d;
    logic [NUM_CH-1:0]   ch_done_q, ch_done_d;

    logic                  pick_valid;
    logic [IdW-1:0]        pick_id;
    logic                  push;
    mo_ord_t               push_data;
    logic                  fifo_pop;
    logic [MO_CH_ID_W-1:0] fifo_pop_id;

`ifdef MO_WR_ARB_LEN_CHECK_EN
    logic [NUM_CH-1:0]   err_q, err_d;
    logic                pick_bad;
`endif

    function automatic logic [IdW-1:0] rr_inc(input logic [IdW-1:0] id);
        return (id == IdW'(NUM_CH - 1)) ? '0 : id + IdW'(1);
    endfunction

    // First valid channel at or after rr_ptr, scanning cyclically.
    always_comb begin
        logic [SumW-1:0] sum;
        logic [IdW-1:0]  cand;
        pick_valid = 1'b0;
        pick_id    = rr_ptr_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            sum = {1'b0, rr_ptr_q} + SumW'(i);
            if (sum >= SumW'(NUM_CH)) sum = sum - SumW'(NUM_CH);
            cand = sum[IdW-1:0];
            if (!pick_valid && ch_req_valid[cand]) begin
                pick_valid = 1'b1;
                pick_id    = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_id_d   = grant_id_q;
        grant_addr_d = grant_addr_q;
        grant_len_d  = grant_len_q;
        ch_req_ready = '0;
        push         = 1'b0;
        ch_done_d    = '0;
`ifdef MO_WR_ARB_LEN_CHECK_EN
        err_d        = '0;
        pick_bad     = (ch_req_len[pick_id] == '0) ||
                       (ch_req_len[pick_id][DATA_SHIFT-1:0] != '0);
`endif

        if (fifo_pop) ch_done_d[IdW'(fifo_pop_id)] = 1'b1;

        unique case (state_q)
            StArb: begin
`ifdef MO_WR_ARB_LEN_CHECK_EN
                // Skip a decision while a reject pulse is out: the rejected
                // channel still shows valid during that cycle.
                if (pick_valid && !ord_full && (err_q == '0)) begin
                    if (pick_bad) begin
                        err_d[pick_id] = 1'b1;
                        rr_ptr_d       = rr_inc(pick_id);
                    end else begin
                        grant_id_d   = pick_id;
                        grant_addr_d = ch_req_addr[pick_id];
                        grant_len_d  = ch_req_len[pick_id];
                        state_d      = StIssue;
                    end
                end
`else
                if (pick_valid && !ord_full) begin
                    grant_id_d   = pick_id;
                    grant_addr_d = ch_req_addr[pick_id];
                    grant_len_d  = ch_req_len[pick_id];
                    state_d      = StIssue;
                end
`endif
            end
            StIssue: begin
                if (start_ready) begin
                    ch_req_ready[grant_id_q] = 1'b1;
                    push                     = 1'b1;
                    rr_ptr_d                 = rr_inc(grant_id_q);
                    state_d                  = StArb;
                end
            end
            default: state_d = StArb;
        endcase

`ifdef MO_WR_ARB_LEN_CHECK_EN
        ch_req_ready = ch_req_ready | err_q;
`endif
    end

    assign push_data   = '{ch_id: MO_CH_ID_W'(grant_id_q), rem_bytes: grant_len_q};
    assign start_valid = (state_q == StIssue);
    assign start_addr  = grant_addr_q;
    assign start_len   = grant_len_q;
    assign ch_done     = ch_done_q;
`ifdef MO_WR_ARB_LEN_CHECK_EN
    assign ch_err      = err_q;
`else
    assign ch_err      = '0;
`endif

    mo_ord_fifo #(
        .Depth     (ORD_DEPTH),
        .DataShift (DATA_SHIFT)
    ) u_ord_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .push_i      (push),
        .push_data_i (push_data),
        .b_done_i    (b_done),
        .b_len_i     (b_len),
        .pop_o       (fifo_pop),
        .pop_id_o    (fifo_pop_id),
        .full_o      (ord_full),
        .empty_o     (ord_empty)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StArb;
            rr_ptr_q     <= '0;
            grant_id_q   <= '0;
            grant_addr_q <= '0;
            grant_len_q  <= '0;
            ch_done_q    <= '0;
`ifdef MO_WR_ARB_LEN_CHECK_EN
            err_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_id_q   <= grant_id_d;
            grant_addr_q <= grant_addr_d;
            grant_len_q  <= grant_len_d;
            ch_done_q    <= ch_done_d;
`ifdef MO_WR_ARB_LEN_CHECK_EN
            err_q        <= err_d;
`endif
        end
    end

    a_cfg: assert property (@(posedge clk)
        ($bits(addr_t) == ADDR_WIDTH) && (NUM_CH >= 2) && (NUM_CH <= MO_WR_MAX_CH));

endmodule
